vic_bus_arbiter: RTL and testbench

VIC_BUS_ARBITER -- requirements
Module: vic_bus_arbiter

---
 rtl/vic_bus_arbiter.sv | 127 ++++++++++++
 tb/tb_vic_bus_arbiter.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/vic_bus_arbiter.sv
// VIC-II / CPU bus arbiter: BA/AEC sequencing for cycle stealing, updated once per bus half-cycle.
// Optional build macro VIC_BUS_STATS_EN enables the saturating stolen-cycle counter.
module vic_bus_arbiter #(
    parameter int BA_DELAY = 3,
    parameter int CNT_W    = 16
) (
    input  logic             clkSys,
    input  logic             reset,
    input  logic             halfTick,
    input  logic             phase,
    input  logic             dmaReq,
    input  logic             vicReq,
    input  logic             cpuReq,
    input  logic             cpuRnW,
    output logic             o_ba,
    output logic             o_aec,
    output logic             o_grantCpu,
    output logic             o_grantVic,
    output logic [1:0]       o_state,
    output logic [CNT_W-1:0] o_stealCount
);
    // state   | meaning
    // IDLE    | normal interleave, BA high
    // BA_WAIT | BA low, CPU writes may still finish, counting phi2 halves
    // STEAL   | VIC owns both halves, AEC low
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BA_WAIT = 2'd1,
        STEAL   = 2'd2
    } state_t;

    localparam int BA_W = (BA_DELAY < 2) ? 1 : $clog2(BA_DELAY + 1);

    state_t          state, state_nxt;
    logic [BA_W-1:0] ba_cnt, ba_cnt_nxt;
    logic            ba_nxt, aec_nxt, gcpu_nxt, gvic_nxt;

    always_ff @(posedge clkSys) begin
        if (reset) begin
            state      <= IDLE;
            ba_cnt     <= '0;
            o_ba       <= 1'b1;
            o_aec      <= 1'b1;
            o_grantCpu <= 1'b0;
            o_grantVic <= 1'b0;
        end else begin
            state      <= state_nxt;
            ba_cnt     <= ba_cnt_nxt;
            o_ba       <= ba_nxt;
            o_aec      <= aec_nxt;
            o_grantCpu <= gcpu_nxt;
            o_grantVic <= gvic_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        ba_cnt_nxt = ba_cnt;
        ba_nxt     = o_ba;
        aec_nxt    = o_aec;
        gcpu_nxt   = o_grantCpu;
        gvic_nxt   = o_grantVic;
        if (halfTick) begin
            // dmaReq low aborts before the terminal-count check can promote to STEAL
            case (state)
                IDLE: begin
                    if (dmaReq) begin
                        state_nxt  = BA_WAIT;
                        ba_cnt_nxt = BA_W'(BA_DELAY);
                    end
                end
                BA_WAIT: begin
                    if (!dmaReq)
                        state_nxt = IDLE;
                    else if (!phase && ba_cnt == '0)
                        state_nxt = STEAL;
                    else if (phase && ba_cnt != '0)
                        ba_cnt_nxt = ba_cnt - 1'b1;
                end
                STEAL: begin
                    if (!dmaReq)
                        state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase

            case (state_nxt)
                BA_WAIT: begin
                    ba_nxt   = 1'b0;
                    aec_nxt  = phase;
                    gvic_nxt = vicReq & ~phase;
                    gcpu_nxt = cpuReq & phase & ~cpuRnW;
                end
                STEAL: begin
                    ba_nxt   = 1'b0;
                    aec_nxt  = 1'b0;
                    gvic_nxt = 1'b1;
                    gcpu_nxt = 1'b0;
                end
                default: begin
                    ba_nxt   = 1'b1;
                    aec_nxt  = phase;
                    gvic_nxt = vicReq & ~phase;
                    gcpu_nxt = cpuReq & phase;
                end
            endcase
        end
    end

    assign o_state = state;

`ifdef VIC_BUS_STATS_EN
    logic [CNT_W-1:0] steal_cnt;

    always_ff @(posedge clkSys) begin
        if (reset)
            steal_cnt <= '0;
        else if (halfTick && phase && state_nxt == STEAL && steal_cnt != '1)
            steal_cnt <= steal_cnt + CNT_W'(1);
    end

    assign o_stealCount = steal_cnt;
`else
    assign o_stealCount = '0;
`endif

endmodule

// File: tb/tb_vic_bus_arbiter.sv
// Self-checking bench for vic_bus_arbiter: directed vector table, saturation sequence, random vs. model.
module tb_vic_bus_arbiter;
    localparam int BA_DELAY = 3;
    localparam int CNT_W    = 4;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;

    logic clkSys = 1'b0;
    logic reset, halfTick, phase, dmaReq, vicReq, cpuReq, cpuRnW;
    logic o_ba, o_aec, o_grantCpu, o_grantVic;
    logic [1:0] o_state;
    logic [CNT_W-1:0] o_stealCount;

    always #5 clkSys = ~clkSys;

    vic_bus_arbiter #(.BA_DELAY(BA_DELAY), .CNT_W(CNT_W)) dut (
        .clkSys(clkSys), .reset(reset), .halfTick(halfTick), .phase(phase),
        .dmaReq(dmaReq), .vicReq(vicReq), .cpuReq(cpuReq), .cpuRnW(cpuRnW),
        .o_ba(o_ba), .o_aec(o_aec), .o_grantCpu(o_grantCpu), .o_grantVic(o_grantVic),
        .o_state(o_state), .o_stealCount(o_stealCount)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: mode 0 idle, 1 waiting for BA delay, 2 stealing.
    int m_mode, m_left, m_cnt;
    int m_ba, m_aec, m_gc, m_gv;

    task automatic model_reset();
        m_mode = 0; m_left = 0; m_cnt = 0;
        m_ba = 1; m_aec = 1; m_gc = 0; m_gv = 0;
    endtask

    task automatic model_step(input int rst, input int ht, input int ph, input int dma,
                              input int vr, input int cr, input int rnw);
        if (rst != 0) begin
            model_reset();
            return;
        end
        if (ht == 0) return;
        if (dma == 0) m_mode = 0;
        else if (m_mode == 0) begin
            m_mode = 1;
            m_left = BA_DELAY;
        end else if (m_mode == 1) begin
            if (ph == 0 && m_left == 0) m_mode = 2;
            else if (ph == 1 && m_left > 0) m_left = m_left - 1;
        end
        if (m_mode == 2) begin
            m_ba = 0; m_aec = 0; m_gc = 0; m_gv = 1;
            if (ph == 1 && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
        end else begin
            m_ba  = (m_mode == 0) ? 1 : 0;
            m_aec = ph;
            m_gv  = (ph == 0) ? vr : 0;
            m_gc  = (ph == 1) ? ((m_mode == 0) ? cr : (cr & (1 - rnw))) : 0;
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cycle(input int rst, input int ht, input int ph, input int dma,
                         input int vr, input int cr, input int rnw);
        @(negedge clkSys);
        reset    = (rst != 0);
        halfTick = (ht != 0);
        phase    = (ph != 0);
        dmaReq   = (dma != 0);
        vicReq   = (vr != 0);
        cpuReq   = (cr != 0);
        cpuRnW   = (rnw != 0);
        @(posedge clkSys);
        #1;
        model_step(rst, ht, ph, dma, vr, cr, rnw);
    endtask

    typedef struct {
        int rst, ht, ph, dma, vr, cr, rnw;
        int e_ba, e_aec, e_gc, e_gv, e_st;
    } vec_t;

    vec_t vecs[$];

    initial begin
        int exp_sat;
        reset = 1'b1; halfTick = 1'b0; phase = 1'b0; dmaReq = 1'b0;
        vicReq = 1'b0; cpuReq = 1'b0; cpuRnW = 1'b1;
        model_reset();

        //            rst ht ph dma vr cr rnw  ba aec gc gv st
        vecs.push_back('{1, 0, 0, 0, 0, 0, 1,  1, 1, 0, 0, 0});
        vecs.push_back('{1, 1, 1, 1, 1, 1, 0,  1, 1, 0, 0, 0});
        vecs.push_back('{1, 0, 0, 0, 0, 0, 1,  1, 1, 0, 0, 0});
        vecs.push_back('{0, 0, 1, 1, 1, 1, 0,  1, 1, 0, 0, 0});
        vecs.push_back('{0, 1, 0, 0, 1, 1, 1,  1, 0, 0, 1, 0});
        vecs.push_back('{0, 1, 1, 0, 1, 1, 1,  1, 1, 1, 0, 0});
        vecs.push_back('{0, 0, 0, 0, 0, 0, 1,  1, 1, 1, 0, 0});
        vecs.push_back('{0, 1, 0, 1, 1, 1, 1,  0, 0, 0, 1, 1});
        vecs.push_back('{0, 1, 1, 1, 0, 1, 1,  0, 1, 0, 0, 1});
        vecs.push_back('{0, 1, 0, 1, 0, 0, 1,  0, 0, 0, 0, 1});
        vecs.push_back('{0, 1, 1, 1, 0, 1, 0,  0, 1, 1, 0, 1});
        vecs.push_back('{0, 1, 0, 1, 1, 0, 1,  0, 0, 0, 1, 1});
        vecs.push_back('{0, 1, 1, 1, 0, 1, 1,  0, 1, 0, 0, 1});
        vecs.push_back('{0, 1, 0, 1, 0, 0, 1,  0, 0, 0, 1, 2});
        vecs.push_back('{0, 1, 1, 1, 0, 1, 1,  0, 0, 0, 1, 2});
        vecs.push_back('{0, 0, 0, 0, 1, 1, 1,  0, 0, 0, 1, 2});
        vecs.push_back('{0, 1, 0, 0, 1, 1, 1,  1, 0, 0, 1, 0});
        vecs.push_back('{0, 1, 1, 1, 0, 1, 1,  0, 1, 0, 0, 1});
        vecs.push_back('{0, 1, 0, 1, 1, 0, 1,  0, 0, 0, 1, 1});
        vecs.push_back('{0, 1, 1, 1, 0, 1, 0,  0, 1, 1, 0, 1});
        vecs.push_back('{0, 1, 0, 0, 1, 1, 1,  1, 0, 0, 1, 0});
        vecs.push_back('{0, 1, 1, 0, 0, 1, 1,  1, 1, 1, 0, 0});
        vecs.push_back('{0, 1, 0, 1, 0, 0, 1,  0, 0, 0, 0, 1});
        vecs.push_back('{0, 1, 1, 1, 0, 0, 1,  0, 1, 0, 0, 1});
        vecs.push_back('{0, 1, 0, 1, 0, 0, 1,  0, 0, 0, 0, 1});
        vecs.push_back('{0, 1, 1, 1, 0, 0, 1,  0, 1, 0, 0, 1});
        vecs.push_back('{0, 1, 0, 1, 0, 0, 1,  0, 0, 0, 0, 1});
        vecs.push_back('{0, 1, 1, 1, 0, 0, 1,  0, 1, 0, 0, 1});
        vecs.push_back('{0, 1, 0, 1, 0, 0, 1,  0, 0, 0, 1, 2});
        vecs.push_back('{1, 0, 1, 1, 1, 1, 1,  1, 1, 0, 0, 0});
        vecs.push_back('{0, 0, 1, 1, 1, 1, 1,  1, 1, 0, 0, 0});

        foreach (vecs[i]) begin
            cycle(vecs[i].rst, vecs[i].ht, vecs[i].ph, vecs[i].dma,
                  vecs[i].vr, vecs[i].cr, vecs[i].rnw);
            chk($sformatf("vec%0d_ba", i),    int'(o_ba),       vecs[i].e_ba);
            chk($sformatf("vec%0d_aec", i),   int'(o_aec),      vecs[i].e_aec);
            chk($sformatf("vec%0d_gcpu", i),  int'(o_grantCpu), vecs[i].e_gc);
            chk($sformatf("vec%0d_gvic", i),  int'(o_grantVic), vecs[i].e_gv);
            chk($sformatf("vec%0d_state", i), int'(o_state),    vecs[i].e_st);
        end

        // Saturation: enter STEAL, then 20 phi2 halves in STEAL.
        cycle(1, 0, 0, 0, 0, 0, 1);
        cycle(0, 1, 0, 1, 0, 0, 1);
        for (int k = 0; k < BA_DELAY; k++) begin
            cycle(0, 1, 1, 1, 0, 0, 1);
            cycle(0, 1, 0, 1, 0, 0, 1);
        end
        chk("sat_entry_state", int'(o_state), 2);
        for (int k = 0; k < 20; k++) begin
            cycle(0, 1, 1, 1, 1, 1, 1);
            chk("sat_gvic", int'(o_grantVic), 1);
            cycle(0, 1, 0, 1, 1, 1, 0);
        end
`ifdef VIC_BUS_STATS_EN
        exp_sat = CNT_MAX;
`else
        exp_sat = 0;
`endif
        chk("sat_count", int'(o_stealCount), exp_sat);
        cycle(0, 0, 1, 0, 0, 0, 1);
        chk("sat_hold_no_tick", int'(o_stealCount), exp_sat);

        // Randomized stimulus against the reference model.
        cycle(1, 0, 0, 0, 0, 0, 1);
        for (int k = 0; k < 600; k++) begin
            int r_rst, r_ht, r_ph, r_dma, exp_cnt;
            r_rst = ($urandom_range(0, 59) == 0) ? 1 : 0;
            r_ht  = int'($urandom_range(0, 1));
            r_ph  = int'($urandom_range(0, 1));
            r_dma = ($urandom_range(0, 7) != 0) ? 1 : 0;
            cycle(r_rst, r_ht, r_ph, r_dma, int'($urandom_range(0, 1)),
                  int'($urandom_range(0, 1)), int'($urandom_range(0, 1)));
`ifdef VIC_BUS_STATS_EN
            exp_cnt = m_cnt;
`else
            exp_cnt = 0;
`endif
            chk("rnd_ba",    int'(o_ba),         m_ba);
            chk("rnd_aec",   int'(o_aec),        m_aec);
            chk("rnd_gcpu",  int'(o_grantCpu),   m_gc);
            chk("rnd_gvic",  int'(o_grantVic),   m_gv);
            chk("rnd_state", int'(o_state),      m_mode);
            chk("rnd_count", int'(o_stealCount), exp_cnt);
            chk("rnd_grant_excl", int'(o_grantCpu & o_grantVic), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
